// File: rtl/alu_cmd_ctrl.sv
// Command sequencer between the RX byte link and the ALU: parses CC/DD frames,
// pulses ALU_EN, waits for the result and returns it low byte first over TX.
module alu_cmd_ctrl #(
    parameter int unsigned TIMEOUT   = 32,
    parameter logic [7:0]  CMD_OPS   = 8'hCC,
    parameter logic [7:0]  CMD_NOOPS = 8'hDD
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  RX_P_DATA,
    input  logic        RX_D_VLD,
    output logic [7:0]  ALU_A,
    output logic [7:0]  ALU_B,
    output logic [3:0]  ALU_FUN,
    output logic        ALU_EN,
    input  logic [15:0] ALU_OUT,
    input  logic        ALU_OUT_VLD,
    output logic [7:0]  TX_P_DATA,
    output logic        TX_D_VLD,
    input  logic        TX_BUSY,
    output logic        ERR,
    output logic        BUSY,
    output logic [2:0]  o_dbg_state
);

    localparam int unsigned CW = $clog2(TIMEOUT) + 1;
    // The counter is bumped on the edge that also raises ERR, so the abort
    // decision is taken while it still holds TIMEOUT-2.
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_A,
        S_GET_B,
        S_GET_FUN,
        S_ISSUE,
        S_WAIT_RES,
        S_SEND_LO,
        S_SEND_HI
    } state_t;

    state_t        r_state;
    logic [7:0]    r_alu_a;
    logic [7:0]    r_alu_b;
    logic [3:0]    r_alu_fun;
    logic          r_alu_en;
    logic [15:0]   r_result;
    logic [CW-1:0] r_tmo_cnt;
    logic [7:0]    r_tx_data;
    logic          r_tx_vld;
    logic          r_err;
    logic          r_busy;

    // TX handshake: a byte transfers on any cycle with TX_D_VLD=1 and
    // TX_BUSY=0; otherwise TX_D_VLD and TX_P_DATA hold their values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_fun <= '0;
            r_alu_en  <= 1'b0;
            r_result  <= '0;
            r_tmo_cnt <= '0;
            r_tx_data <= '0;
            r_tx_vld  <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_alu_en <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (RX_D_VLD) begin
                        if (RX_P_DATA == CMD_OPS) begin
                            r_state <= S_GET_A;
                            r_busy  <= 1'b1;
                        end else if (RX_P_DATA == CMD_NOOPS) begin
                            r_state <= S_GET_FUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_GET_A: begin
                    if (RX_D_VLD) begin
                        r_alu_a <= RX_P_DATA;
                        r_state <= S_GET_B;
                    end
                end
                S_GET_B: begin
                    if (RX_D_VLD) begin
                        r_alu_b <= RX_P_DATA;
                        r_state <= S_GET_FUN;
                    end
                end
                S_GET_FUN: begin
                    if (RX_D_VLD) begin
                        r_alu_fun <= RX_P_DATA[3:0];
                        r_alu_en  <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_tmo_cnt <= '0;
                    r_state   <= S_WAIT_RES;
                end
                S_WAIT_RES: begin
                    if (ALU_OUT_VLD) begin
                        r_result  <= ALU_OUT;
                        r_tx_data <= ALU_OUT[7:0];
                        r_tx_vld  <= 1'b1;
                        r_state   <= S_SEND_LO;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                        if (r_tmo_cnt == TMO_LAST) begin
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_SEND_LO: begin
                    if (!TX_BUSY) begin
                        r_tx_data <= r_result[15:8];
                        r_state   <= S_SEND_HI;
                    end
                end
                S_SEND_HI: begin
                    if (!TX_BUSY) begin
                        r_tx_vld <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ALU_A       = r_alu_a;
    assign ALU_B       = r_alu_b;
    assign ALU_FUN     = r_alu_fun;
    assign ALU_EN      = r_alu_en;
    assign TX_P_DATA   = r_tx_data;
    assign TX_D_VLD    = r_tx_vld;
    assign ERR         = r_err;
    assign BUSY        = r_busy;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Self-checking bench for alu_cmd_ctrl: frame-level reference model with an
// emulated ALU and transmitter, checked every cycle from one process.
module tb_alu_cmd_ctrl;

    localparam int TO = 32;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic [7:0]  ALU_A;
    logic [7:0]  ALU_B;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VLD;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        TX_BUSY;
    logic        ERR;
    logic        BUSY;
    logic [2:0]  dbg_state;

    alu_cmd_ctrl #(.TIMEOUT(TO), .CMD_OPS(8'hCC), .CMD_NOOPS(8'hDD)) dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD), .TX_P_DATA(TX_P_DATA),
        .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY), .ERR(ERR), .BUSY(BUSY),
        .o_dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    int checks, errors, cyc;
    int cmd_cycle, fun_cycle, done_cycle, en_seen, alu_vld_cycle;
    int tx_start, tx_idx, bp_cnt, alu_delay, busy_pct, exp_rd;
    bit to_frame, bp_mode, tx_active;
    logic [15:0] en_res;
    logic [7:0]  ma, mb;
    logic [3:0]  mf;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];

    // Emulated ALU: 0 add, 1 sub, 2 mul, 3 and, 4 or, 5 xor, else {A,B}.
    function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] f);
        case (f)
            4'd0:    return {8'h00, a} + {8'h00, b};
            4'd1:    return {8'h00, a} - {8'h00, b};
            4'd2:    return a * b;
            4'd3:    return {8'h00, a & b};
            4'd4:    return {8'h00, a | b};
            4'd5:    return {8'h00, a ^ b};
            default: return {a, b};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic check_cycle();
        bit exp_err, exp_en, exp_busy;
        if (RST) begin
            tx_active = 1'b0;
            tx_idx    = 0;
            en_seen   = -1000;
            return;
        end
        exp_err = to_frame && (fun_cycle >= 0) && (cyc == fun_cycle + 1 + TO);
        chk("err", ERR, exp_err);
        if (exp_err) done_cycle = cyc;
        exp_en = (fun_cycle >= 0) && (cyc == fun_cycle + 1);
        chk("alu_en", ALU_EN, exp_en);
        if (ALU_EN) begin
            en_seen = cyc;
            en_res  = alu_f(ALU_A, ALU_B, ALU_FUN);
        end
        exp_busy = (cmd_cycle >= 0) && (cyc > cmd_cycle) &&
                   !((done_cycle > cmd_cycle) && (cyc >= done_cycle));
        chk("busy", BUSY, exp_busy);
        if (fun_cycle >= 0 && cyc > fun_cycle && exp_busy) begin
            chk("alu_a", ALU_A, ma);
            chk("alu_b", ALU_B, mb);
            chk("alu_fun", ALU_FUN, mf);
        end
        if (!to_frame && alu_vld_cycle >= 0 && cyc == alu_vld_cycle + 1) begin
            tx_active = 1'b1;
            tx_start  = cyc;
        end
        chk("tx_vld", TX_D_VLD, tx_active);
        if (TX_D_VLD && tx_active) begin
            if (exp_rd < exp_q.size()) begin
                chk("tx_data", TX_P_DATA, exp_q[exp_rd]);
            end else begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected act=%0h exp=none cyc=%0d", TX_P_DATA, cyc);
            end
            if (TX_BUSY) begin
                if (tx_idx == 0) bp_cnt++;
            end else begin
                got_q.push_back(TX_P_DATA);
                if (bp_mode && tx_idx == 0) chk("bp_accept_cycle", cyc, tx_start + 5);
                exp_rd++;
                tx_idx++;
                if (tx_idx == 2) begin
                    tx_active  = 1'b0;
                    tx_idx     = 0;
                    done_cycle = cyc + 1;
                end
            end
        end
    endtask

    task automatic drive_env();
        bit in_win;
        ALU_OUT_VLD = 1'b0;
        ALU_OUT     = 16'($urandom);
        in_win = (fun_cycle >= 0) && (cyc > fun_cycle) && (cyc <= fun_cycle + 1 + TO);
        if (!to_frame && en_seen >= 0 && cyc == en_seen + alu_delay) begin
            ALU_OUT_VLD   = 1'b1;
            ALU_OUT       = en_res;
            alu_vld_cycle = cyc;
        end else if ((!in_win || cyc == alu_vld_cycle + 1) && $urandom_range(0, 7) == 0) begin
            ALU_OUT_VLD = 1'b1;
        end
        if (bp_mode) TX_BUSY = (bp_cnt < 5);
        else         TX_BUSY = (int'($urandom_range(0, 99)) < busy_pct);
    endtask

    task automatic tick();
        @(negedge CLK);
        check_cycle();
        @(posedge CLK);
        cyc++;
        #1;
        drive_env();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        tick();
        RX_D_VLD  = 1'b0;
    endtask

    task automatic do_reset();
        RST      = 1'b1;
        RX_D_VLD = 1'b0;
        tick();
        tick();
        RST       = 1'b0;
        cmd_cycle = -1;
        fun_cycle = -1000;
        to_frame  = 1'b0;
        bp_mode   = 1'b0;
        ma = 8'h00;
        mb = 8'h00;
        mf = 4'h0;
        exp_rd = exp_q.size();
        chk("rst_alu_a", ALU_A, 0);
        chk("rst_alu_b", ALU_B, 0);
        chk("rst_alu_fun", ALU_FUN, 0);
        chk("rst_alu_en", ALU_EN, 0);
        chk("rst_tx_data", TX_P_DATA, 0);
        chk("rst_tx_vld", TX_D_VLD, 0);
        chk("rst_err", ERR, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_state_idle", dbg_state, 0);
    endtask

    task automatic send_frame(input bit ops, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] fb, input bit to, input int dly,
                              input int gap, input bit junk);
        logic [15:0] r;
        int guard;
        fun_cycle = -1000;
        to_frame  = to;
        alu_delay = dly;
        bp_cnt    = 0;
        if (ops) begin
            ma = a;
            mb = b;
        end
        mf = fb[3:0];
        if (!to) begin
            r = alu_f(ma, mb, mf);
            exp_q.push_back(r[7:0]);
            exp_q.push_back(r[15:8]);
        end
        cmd_cycle = cyc;
        send_byte(ops ? 8'hCC : 8'hDD);
        if (ops) begin
            idle($urandom_range(0, gap));
            send_byte(a);
            idle($urandom_range(0, gap));
            send_byte(b);
        end
        idle($urandom_range(0, gap));
        fun_cycle = cyc;
        send_byte(fb);
        if (junk) begin
            send_byte(8'h55);
            send_byte(8'($urandom));
        end
        guard = 0;
        while (!(done_cycle > cmd_cycle && cyc >= done_cycle) && guard < 400) begin
            tick();
            guard++;
        end
        checks++;
        if (guard >= 400) begin
            errors++;
            $display("FAIL frame_done act=stuck exp=done cyc=%0d", cyc);
        end
        tick();
    endtask

    task automatic chk_pair(input string name, input int n0, input logic [7:0] lo,
                            input logic [7:0] hi);
        chk({name, "_count"}, got_q.size() - n0, 2);
        if (got_q.size() - n0 == 2) begin
            chk({name, "_lo"}, got_q[n0], lo);
            chk({name, "_hi"}, got_q[n0 + 1], hi);
        end
    endtask

    initial begin
        int n0;
        logic [7:0] g;
        checks = 0; errors = 0; cyc = 0;
        cmd_cycle = -1; fun_cycle = -1000; done_cycle = -1; en_seen = -1000;
        alu_vld_cycle = -1000; tx_start = 0; tx_idx = 0; bp_cnt = 0;
        alu_delay = 1; busy_pct = 0; exp_rd = 0;
        to_frame = 1'b0; bp_mode = 1'b0; tx_active = 1'b0;
        en_res = '0; ma = '0; mb = '0; mf = '0;
        RST = 1'b1; RX_P_DATA = '0; RX_D_VLD = 1'b0;
        ALU_OUT = '0; ALU_OUT_VLD = 1'b0; TX_BUSY = 1'b0;

        do_reset();
        idle(2);

        // Garbage byte in IDLE leaves the block idle.
        send_byte(8'hAB);
        chk("garbage_busy", BUSY, 0);
        idle(2);

        busy_pct = 0;
        n0 = got_q.size();
        send_frame(1, 8'h12, 8'h34, 8'h00, 0, 1, 0, 0);
        chk_pair("add", n0, 8'h46, 8'h00);

        n0 = got_q.size();
        send_frame(1, 8'hFF, 8'hFF, 8'h02, 0, 1, 1, 0);
        chk_pair("mul", n0, 8'h01, 8'hFE);
        n0 = got_q.size();
        send_frame(0, 8'h00, 8'h00, 8'h01, 0, 2, 1, 0);
        chk_pair("reuse_sub", n0, 8'h00, 8'h00);

        bp_mode = 1'b1;
        n0 = got_q.size();
        send_frame(1, 8'h05, 8'h06, 8'hF2, 0, 1, 0, 0);
        chk_pair("backpressure", n0, 8'h1E, 8'h00);
        bp_mode = 1'b0;

        n0 = got_q.size();
        send_frame(1, 8'h01, 8'h01, 8'h00, 1, 1, 0, 0);
        chk("timeout_no_tx", got_q.size() - n0, 0);
        chk("timeout_idle_busy", BUSY, 0);

        n0 = got_q.size();
        send_frame(1, 8'h03, 8'h02, 8'h01, 0, 3, 0, 1);
        chk_pair("drop_in_wait", n0, 8'h01, 8'h00);

        // Abandon a frame mid-way, then reuse operands that reset cleared.
        fun_cycle = -1000;
        to_frame  = 1'b0;
        cmd_cycle = cyc;
        send_byte(8'hCC);
        send_byte(8'h07);
        do_reset();
        idle(1);
        n0 = got_q.size();
        send_frame(0, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0);
        chk_pair("after_reset_noops", n0, 8'h00, 8'h00);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 2))
                0:       busy_pct = 0;
                1:       busy_pct = 30;
                default: busy_pct = 60;
            endcase
            if ($urandom_range(0, 3) == 0) begin
                g = 8'($urandom);
                if (g == 8'hCC || g == 8'hDD) g = g ^ 8'h01;
                send_byte(g);
            end
            send_frame(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom),
                       ($urandom_range(0, 7) == 0), int'($urandom_range(1, 4)), 2,
                       1'($urandom_range(0, 1)));
            idle($urandom_range(0, 2));
        end

        chk("all_bytes_sent", exp_rd, exp_q.size());
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
